// File: rtl/fcc_pkg.sv
// Shared constants, state encoding and helpers for the FCC label readout engine.
package fcc_pkg;

    // Default range-grid geometry and label width
    localparam int unsigned FCC_ROWS       = 30;
    localparam int unsigned FCC_COLS       = 30;
    localparam int unsigned FCC_COL_W      = 5;
    localparam int unsigned FCC_LABEL_W    = 16;
    localparam int unsigned FCC_ROW_W      = 8;

    // Output FIFO depth; also the cap on reads outstanding at any time
    localparam int unsigned FCC_FIFO_DEPTH = 3;

    // Readout FSM state encoding
    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } rd_state_e;

    // Linear cell index in row-major order
    function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/fcc_readout_fifo.sv
// Three-entry shift FIFO of packed {row, col, label, is_ground} cells. Entry 0 is
// always the head, so the head outputs come straight from a register.
module fcc_readout_fifo
    import fcc_pkg::*;
#(
    parameter int unsigned W = 30
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [FCC_FIFO_DEPTH];
    logic [W-1:0] w_mem_d [FCC_FIFO_DEPTH];
    logic [1:0]   r_count;
    logic [1:0]   w_count_d;
    logic [1:0]   w_wr_idx;

    // Next-state: shift down on pop, then write the new cell behind the survivors
    always_comb begin
        w_wr_idx   = r_count - {1'b0, i_pop};
        w_count_d  = r_count + {1'b0, i_push} - {1'b0, i_pop};
        w_mem_d[0] = i_pop ? r_mem[1] : r_mem[0];
        w_mem_d[1] = i_pop ? r_mem[2] : r_mem[1];
        w_mem_d[2] = r_mem[2];
        for (int unsigned i = 0; i < FCC_FIFO_DEPTH; i++) begin
            if (i_push && (w_wr_idx == 2'(i))) begin
                w_mem_d[i] = i_data;
            end
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 2'd0;
            for (int unsigned i = 0; i < FCC_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_count_d;
            for (int unsigned i = 0; i < FCC_FIFO_DEPTH; i++) begin
                r_mem[i] <= w_mem_d[i];
            end
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem[0];

endmodule

// File: rtl/fcc_label_readout.sv
// Scans the FCC point/label memory in row-major order after clustering and streams
// each cell's (row, col, label, is_ground) over valid/ready, optionally dropping
// ground cells. Reads are credit-limited so the 3-entry FIFO can never overflow.
module fcc_label_readout
    import fcc_pkg::*;
#(
    parameter int unsigned ROWS    = FCC_ROWS,
    parameter int unsigned COLS    = FCC_COLS,
    parameter int unsigned COL_W   = FCC_COL_W,
    parameter int unsigned LABEL_W = FCC_LABEL_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_skip_ground,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [FCC_ROW_W-1:0] o_rd_row,
    output logic [COL_W-1:0]     o_rd_col,
    input  logic [LABEL_W-1:0]   i_rd_label,
    input  logic                 i_rd_is_ground,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [FCC_ROW_W-1:0] o_out_row,
    output logic [COL_W-1:0]     o_out_col,
    output logic [LABEL_W-1:0]   o_out_label,
    output logic                 o_out_is_ground
);

    localparam int unsigned ENTRY_W = FCC_ROW_W + COL_W + LABEL_W + 1;

    rd_state_e            r_state;
    logic                 r_skip;
    logic [FCC_ROW_W-1:0] r_nrow;       // next address to issue
    logic [COL_W-1:0]     r_ncol;
    logic                 r_rd_valid;   // address on the read port is a live read
    logic                 r_inflight;   // read data on i_rd_* belongs to the tag below
    logic [FCC_ROW_W-1:0] r_tag_row;
    logic [COL_W-1:0]     r_tag_col;

    logic [1:0]           w_count;
    logic [2:0]           w_committed;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_last;
    logic                 w_col_wrap;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_head;

    assign w_pop       = o_out_valid & i_out_ready;
    assign w_push      = r_inflight & ~(r_skip & i_rd_is_ground);
    assign w_push_data = {r_tag_row, r_tag_col, i_rd_label, i_rd_is_ground};

    // Slots already promised after this edge; counting the pop keeps full throughput
    assign w_committed = {1'b0, w_count} + {2'b00, r_rd_valid} + {2'b00, r_inflight}
                       - {2'b00, w_pop};
    assign w_issue     = (r_state == StScan) && (w_committed < 3'(FCC_FIFO_DEPTH));
    assign w_col_wrap  = (r_ncol == COL_W'(COLS - 1));
    assign w_last      = (r_nrow == FCC_ROW_W'(ROWS - 1)) && w_col_wrap;

    // Readout FSM: address generation, busy and done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_skip     <= 1'b0;
            r_nrow     <= '0;
            r_ncol     <= '0;
            r_rd_valid <= 1'b0;
            o_rd_row   <= '0;
            o_rd_col   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
            o_done     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_skip   <= i_skip_ground;
                        r_nrow   <= '0;
                        r_ncol   <= '0;
                        o_rd_row <= '0;
                        o_rd_col <= '0;
                        o_busy   <= 1'b1;
                        r_state  <= StScan;
                    end
                end
                StScan: begin
                    if (w_issue) begin
                        o_rd_row <= r_nrow;
                        o_rd_col <= r_ncol;
                        if (w_last) begin
                            r_state <= StDrain;
                        end else if (w_col_wrap) begin
                            r_ncol <= '0;
                            r_nrow <= r_nrow + 1'b1;
                        end else begin
                            r_ncol <= r_ncol + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (!r_rd_valid && !r_inflight && (w_count == 2'd0)) begin
                        o_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // In-flight tag: remembers which cell the memory is returning this cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_tag_row  <= '0;
            r_tag_col  <= '0;
        end else begin
            r_inflight <= r_rd_valid;
            r_tag_row  <= o_rd_row;
            r_tag_col  <= o_rd_col;
        end
    end

    fcc_readout_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_valid (o_out_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign {o_out_row, o_out_col, o_out_label, o_out_is_ground} = w_head;

endmodule

// File: tb/tb_fcc_label_readout.sv
// Directed/randomized bench for fcc_label_readout: a 30x30 instance against a
// row-major reference queue, plus a 2x3 all-ground instance.
module tb_fcc_label_readout;

    localparam int NR    = 30;
    localparam int NC    = 30;
    localparam int NCELL = NR * NC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, skip_ground, busy, done;
    logic [7:0]  rd_row;
    logic [4:0]  rd_col;
    logic [15:0] rd_label;
    logic        rd_is_ground;
    logic        out_valid, out_ready;
    logic [7:0]  out_row;
    logic [4:0]  out_col;
    logic [15:0] out_label;
    logic        out_is_ground;

    logic        s_start, s_skip, s_busy, s_done;
    logic [7:0]  s_rd_row;
    logic [4:0]  s_rd_col;
    logic [15:0] s_rd_label;
    logic        s_rd_is_ground;
    logic        s_out_valid, s_ready;
    logic [7:0]  s_out_row;
    logic [4:0]  s_out_col;
    logic [15:0] s_out_label;
    logic        s_out_is_ground;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] lab [NCELL];
    logic        gnd [NCELL];

    always #5 clk = ~clk;

    fcc_label_readout u_dut (
        .i_clk (clk), .i_rst (rst), .i_start (start), .i_skip_ground (skip_ground),
        .o_busy (busy), .o_done (done), .o_rd_row (rd_row), .o_rd_col (rd_col),
        .i_rd_label (rd_label), .i_rd_is_ground (rd_is_ground),
        .o_out_valid (out_valid), .i_out_ready (out_ready), .o_out_row (out_row),
        .o_out_col (out_col), .o_out_label (out_label), .o_out_is_ground (out_is_ground)
    );

    fcc_label_readout #(
        .ROWS (2), .COLS (3)
    ) u_small (
        .i_clk (clk), .i_rst (rst), .i_start (s_start), .i_skip_ground (s_skip),
        .o_busy (s_busy), .o_done (s_done), .o_rd_row (s_rd_row), .o_rd_col (s_rd_col),
        .i_rd_label (s_rd_label), .i_rd_is_ground (s_rd_is_ground),
        .o_out_valid (s_out_valid), .i_out_ready (s_ready), .o_out_row (s_out_row),
        .o_out_col (s_out_col), .o_out_label (s_out_label), .o_out_is_ground (s_out_is_ground)
    );

    // Registered-read memory models: data appears one clock after the address
    always @(posedge clk) begin
        int idx;
        idx = int'(rd_row) * NC + int'(rd_col);
        if (idx < NCELL) begin
            rd_label     <= lab[idx];
            rd_is_ground <= gnd[idx];
        end
        s_rd_label     <= 16'(int'(s_rd_row) * 3 + int'(s_rd_col));
        s_rd_is_ground <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One scan of the 30x30 instance checked against the reference cell queue
    task automatic run_scan(input string nm, input bit skip, input int unsigned ready_pct,
                            input int restart_beat, input int rst_beat);
        logic [29:0] exp_q [$];
        logic [29:0] head;
        int n_exp, beats, bad, gaps, gnd_out, done_cnt, done_k, last_hs, first_v;
        int max_out, outst;
        bit rdy, restarted, stop;
        exp_q = {};
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (!(skip && gnd[r*NC+c])) begin
                    exp_q.push_back({8'(r), 5'(c), lab[r*NC+c], gnd[r*NC+c]});
                end
            end
        end
        n_exp = exp_q.size();
        beats = 0; bad = 0; gaps = 0; gnd_out = 0; done_cnt = 0;
        done_k = -1; last_hs = -1; first_v = -1; max_out = 0;
        restarted = 1'b0; stop = 1'b0;
        @(negedge clk);
        start = 1'b1; skip_ground = skip; out_ready = 1'b0;
        for (int k = 0; k < 8000 && !stop; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (restart_beat >= 0 && !restarted && beats >= restart_beat) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (k == 0) chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (busy && !skip) begin
                outst = int'(rd_row) * NC + int'(rd_col) + 1 - beats;
                if (outst > max_out) max_out = outst;
            end
            head = {out_row, out_col, out_label, out_is_ground};
            if (out_valid) begin
                if (first_v < 0) first_v = k;
                if (exp_q.size() == 0 || head !== exp_q[0]) bad++;
                if (out_is_ground) gnd_out++;
            end else if (!skip && ready_pct == 100 && first_v >= 0 && beats < n_exp) begin
                gaps++;
            end
            rdy = ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beats++;
                last_hs = k;
            end
            if (rst_beat >= 0 && beats == rst_beat) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_valid"}, 32'(out_valid), 32'd0);
                chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
                chk({nm, "_rst_done"}, 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid || busy || done) bad++;
                end
                chk({nm, "_quiet_after_rst"}, 32'(bad), 32'd0);
                return;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
                stop = 1'b1;
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (out_valid || done) bad++;
        end
        chk({nm, "_data_order"}, 32'(bad), 32'd0);
        chk({nm, "_beat_count"}, 32'(beats), 32'(n_exp));
        chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
        if (!skip) begin
            chk({nm, "_first_valid"}, 32'(first_v), 32'd3);
            // handshake at edge k+1, FIFO seen empty after it, done on the next edge
            chk({nm, "_done_timing"}, 32'(done_k), 32'(last_hs + 2));
            chk({nm, "_max_outstanding"}, 32'(max_out <= 3), 32'd1);
        end
        if (!skip && ready_pct == 100) chk({nm, "_gaps"}, 32'(gaps), 32'd0);
        if (skip) chk({nm, "_ground_out"}, 32'(gnd_out), 32'd0);
    endtask

    initial begin
        int s_beats, s_dcnt, s_dk;
        rst = 1'b1; start = 1'b0; skip_ground = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_skip = 1'b0; s_ready = 1'b1;
        for (int i = 0; i < NCELL; i++) begin
            lab[i] = 16'(i + 1);
            gnd[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_addr", {19'd0, rd_row, rd_col}, 32'd0);
        chk("reset_out_data", {2'd0, out_row, out_col, out_label, out_is_ground}, 32'd0);
        chk("reset_small_busy", 32'(s_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_scan("full", 1'b0, 100, -1, -1);

        for (int i = 0; i < NCELL; i++) lab[i] = 16'($urandom);
        gnd[0] = 1'b1;
        gnd[5*NC+7] = 1'b1;
        gnd[NCELL-1] = 1'b1;
        run_scan("skip", 1'b1, 100, -1, -1);

        for (int i = 0; i < NCELL; i++) begin
            lab[i] = 16'($urandom);
            gnd[i] = ($urandom_range(3) == 0);
        end
        run_scan("backpressure", 1'b0, 30, -1, -1);

        run_scan("rst_mid", 1'b0, 100, -1, 400);
        run_scan("after_rst", 1'b0, 100, -1, -1);

        run_scan("start_busy", 1'b0, 70, 10, -1);

        // 2x3 grid, every cell ground and skipped
        s_beats = 0; s_dcnt = 0; s_dk = -1;
        @(negedge clk);
        s_start = 1'b1; s_skip = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_out_valid) s_beats++;
            if (s_done) begin
                s_dcnt++;
                s_dk = k;
            end
        end
        chk("small_beats", 32'(s_beats), 32'd0);
        chk("small_done_pulses", 32'(s_dcnt), 32'd1);
        // last of 6 addresses at edge 6, its data captured at edge 8, done at edge 9
        chk("small_done_timing", 32'(s_dk), 32'd9);
        chk("small_busy_after", 32'(s_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fcc_label_readout.md
Name: fcc_label_readout

Overview:
Scan engine that drains the FCC point/label memory after clustering completes. It walks every cell of the ROWS x COLS range grid in row-major order and drives the memory's registered read port, which returns data 1 cycle after the address. It streams each cell's (row, col, label, is_ground) to downstream cluster statistics over a valid/ready interface. Ground cells are optionally suppressed.

Parameters:
ROWS, 30, grid rows (max 256; row address is 8 bits)
COLS, 30, grid columns (COLS <= 2^COL_W)
COL_W, 5, column address width
LABEL_W, 16, label width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle scan request; ignored while busy=1
skip_ground  in  1  sampled with start; 1 = do not emit cells whose is_ground=1
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at scan completion
rd_row  out  8  memory read row address
rd_col  out  COL_W  memory read column address
rd_label  in  LABEL_W  memory read data, valid 1 cycle after address
rd_is_ground  in  1  memory ground flag, valid 1 cycle after address
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_row  out  8  cell row
out_col  out  COL_W  cell column
out_label  out  LABEL_W  cell label
out_is_ground  out  1  cell ground flag (always 0 when skip_ground=1)

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, out_valid=0, rd_row=0, rd_col=0, all out_* data=0, FIFO emptied, in-flight flag cleared, counters=0. Reset mid-scan abandons the scan. No beat is emitted after reset release until a new start.
- FSM states:
  - IDLE: on start, latch skip_ground, clear counters, go to SCAN.
  - SCAN: issue reads.
  - DRAIN: after the last address is issued, wait until the in-flight read has returned and the FIFO is empty.
  - DONE: pulse done for one cycle, then go to IDLE.
- Address generation: rd_row/rd_col are registered counters. The order is (0,0),(0,1)..(0,COLS-1),(1,0)..(ROWS-1,COLS-1). When col=COLS-1, col wraps to 0 and row increments. Exactly ROWS*COLS reads are issued per scan. A read is issued on a cycle only if (fifo_count + inflight) < 3.
- A read issued in cycle N is paired with the address registered at N. Its return data is captured in cycle N+1 and tagged with that address via a 1-deep in-flight tag register.
- Captured data is pushed into a 3-entry FIFO unless latched skip_ground=1 and rd_is_ground=1; in that case the data is discarded.
- Output side: out_valid = FIFO non-empty, with registered outputs from the FIFO head. A pop happens when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* must stay stable.
  - A simultaneous push and pop in one cycle is legal; the count is unchanged.
- Latency: if start is sampled at edge 0, the first address is on rd_row/rd_col after edge 1, data is captured at edge 2, and out_valid=1 after edge 3 (when not skipped). With out_ready held at 1, throughput is 1 beat/cycle with no bubbles.
- done fires the cycle after the FSM sees all reads issued, no read in flight, and the FIFO empty. If every cell is ground and skip_ground=1, done still fires and zero beats are emitted.
- start during busy is ignored; busy does not extend.
- busy=0 in IDLE only; busy=1 in SCAN, DRAIN, and DONE.

Decomposition:
- Shared package fcc_pkg:
  - grid constants ROWS, COLS, COL_W, LABEL_W
  - cell-index function idx = row*COLS + col
  - readout FSM state encoding
  - FIFO depth constant (3)
- One sub-module: fcc_readout_fifo, a 3-entry synchronous FIFO of {row, col, label, is_ground} with push, pop, count, and registered head outputs, plus async active-high reset.

Test Plan:
- Full scan, no backpressure: memory preloaded with label=idx+1 and all ground=0; pulse start with skip_ground=0 and out_ready=1 → 900 beats in row-major order with out_label = row*30+col+1. First out_valid 3 cycles after start, no gaps, done 1 cycle after the last handshake.
- Ground skip: cells (0,0), (5,7), and (29,29) marked ground; skip_ground=1 → 897 beats, those three coordinates absent, all out_is_ground=0, done still pulses once.
- Backpressure: out_ready driven by a random 30% duty pattern → still 900 beats in order, no duplicates or losses. out_* stable across every stalled cycle, and no more than 3 reads outstanding.
- Reset mid-scan: assert rst at beat 400 → out_valid, busy, and done drop immediately. A new start then yields a full 900-beat scan from (0,0).
- Start while busy: second start pulse at beat 10 → ignored; exactly one 900-beat scan and one done pulse.
- Small grid and all-ground case: ROWS=2, COLS=3, all cells ground, skip_ground=1 → zero beats, done 1 cycle after DRAIN completes, busy low afterwards.
